// File: rtl/quad_decoder.sv
// ============================================================================
//  quad_decoder : x4 quadrature decoder with Z index, PPR measurement,
//                 illegal-transition counting and a coherent snapshot port.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module quad_decoder #(
  parameter int POS_W = 32,
  parameter int PPR_W = 16,
  parameter int ERR_W = 16,
  parameter bit ZHOME = 1'b0
) (
  input  logic                    Clk,
  input  logic                    rsetN,
  input  logic                    Ai,
  input  logic                    Bi,
  input  logic                    Zi,
  input  logic                    Clr,
  input  logic                    SnapReq,
  output logic signed [POS_W-1:0] Position,
  output logic [31:0]             ZCount,
  output logic [PPR_W-1:0]        PPR,
  output logic                    CycleDone,
  output logic                    Dir,
  output logic [ERR_W-1:0]        ErrCount,
  output logic                    ErrFlag,
  output logic                    SnapValid,
  output logic signed [POS_W-1:0] SnapPos,
  output logic [31:0]             SnapZ,
  output logic [ERR_W-1:0]        SnapErr
);

  localparam logic [POS_W-1:0] c_POS_ONE = POS_W'(1);
  localparam logic [PPR_W-1:0] c_PPR_ONE = PPR_W'(1);
  localparam logic [ERR_W-1:0] c_ERR_ONE = ERR_W'(1);

  logic signed [POS_W-1:0] r_pos;
  logic [31:0]             r_zcount;
  logic [PPR_W-1:0]        r_ppr;
  logic [PPR_W-1:0]        r_edge;
  logic                    r_cycle_done;
  logic                    r_dir;
  logic [ERR_W-1:0]        r_err;
  logic                    r_err_flag;
  logic                    r_snap_valid;
  logic signed [POS_W-1:0] r_snap_pos;
  logic [31:0]             r_snap_z;
  logic [ERR_W-1:0]        r_snap_err;
  logic [1:0]              r_prev_ab;
  logic                    r_prev_z;
  logic                    r_armed;
  logic                    r_zseen;

  logic [1:0] w_ab;
  logic       w_fwd;
  logic       w_rev;
  logic       w_ill;
  logic       w_step;
  logic       w_zrise;

  assign w_ab    = {Ai, Bi};
  assign w_step  = w_fwd | w_rev;
  assign w_zrise = Zi & ~r_prev_z;

  // Gray order 00 -> 10 -> 11 -> 01 is forward; a two-bit change is illegal.
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    w_ill = 1'b0;
    case ({r_prev_ab, w_ab})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: w_rev = 1'b1;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: w_ill = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge rsetN) begin
    if (!rsetN) begin
      r_pos        <= '0;
      r_zcount     <= '0;
      r_ppr        <= '0;
      r_edge       <= '0;
      r_cycle_done <= 1'b0;
      r_dir        <= 1'b0;
      r_err        <= '0;
      r_err_flag   <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_pos   <= '0;
      r_snap_z     <= '0;
      r_snap_err   <= '0;
      r_prev_ab    <= 2'b00;
      r_prev_z     <= 1'b0;
      r_armed      <= 1'b0;
      r_zseen      <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      r_snap_valid <= SnapReq;
      r_prev_ab    <= w_ab;
      r_prev_z     <= Zi;
      // Snapshot sees pre-update values, so it is unaffected by Clr.
      if (SnapReq) begin
        r_snap_pos <= r_pos;
        r_snap_z   <= r_zcount;
        r_snap_err <= r_err;
      end
      if (!r_armed) begin
        r_armed <= 1'b1;
      end else if (Clr) begin
        r_pos      <= '0;
        r_zcount   <= '0;
        r_ppr      <= '0;
        r_edge     <= '0;
        r_err      <= '0;
        r_err_flag <= 1'b0;
        r_zseen    <= 1'b0;
      end else begin
        if (w_ill) begin
          if (r_err != '1) r_err <= r_err + c_ERR_ONE;
          r_err_flag <= 1'b1;
        end
        if (w_fwd) begin
          r_pos <= r_pos + c_POS_ONE;
          r_dir <= 1'b1;
        end else if (w_rev) begin
          r_pos <= r_pos - c_POS_ONE;
          r_dir <= 1'b0;
        end
        if (w_zrise) begin
          r_zcount <= r_zcount + 32'd1;
          r_edge   <= w_step ? c_PPR_ONE : '0;
          r_zseen  <= 1'b1;
          if (r_zseen) begin
            r_ppr        <= r_edge;
            r_cycle_done <= 1'b1;
          end
          if (ZHOME) r_pos <= '0;
        end else if (w_step && r_edge != '1) begin
          r_edge <= r_edge + c_PPR_ONE;
        end
      end
    end
  end

  assign Position  = r_pos;
  assign ZCount    = r_zcount;
  assign PPR       = r_ppr;
  assign CycleDone = r_cycle_done;
  assign Dir       = r_dir;
  assign ErrCount  = r_err;
  assign ErrFlag   = r_err_flag;
  assign SnapValid = r_snap_valid;
  assign SnapPos   = r_snap_pos;
  assign SnapZ     = r_snap_z;
  assign SnapErr   = r_snap_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
//  tb_quad_decoder : scoreboard bench for quad_decoder (ZHOME=0 and ZHOME=1).
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_quad_decoder;

  logic Clk = 1'b0;
  logic rsetN = 1'b0;
  logic Ai = 1'b0, Bi = 1'b0, Zi = 1'b0, Clr = 1'b0, SnapReq = 1'b0;

  logic signed [31:0] Position, SnapPos, Position_h, SnapPos_h;
  logic [31:0]        ZCount, SnapZ, ZCount_h, SnapZ_h;
  logic [15:0]        PPR, ErrCount, SnapErr, PPR_h, ErrCount_h, SnapErr_h;
  logic               CycleDone, Dir, ErrFlag, SnapValid;
  logic               CycleDone_h, Dir_h, ErrFlag_h, SnapValid_h;

  always #5 Clk = ~Clk;

  quad_decoder #(.POS_W(32), .PPR_W(16), .ERR_W(16), .ZHOME(1'b0)) u_dut (
    .Clk(Clk), .rsetN(rsetN), .Ai(Ai), .Bi(Bi), .Zi(Zi), .Clr(Clr), .SnapReq(SnapReq),
    .Position(Position), .ZCount(ZCount), .PPR(PPR), .CycleDone(CycleDone), .Dir(Dir),
    .ErrCount(ErrCount), .ErrFlag(ErrFlag), .SnapValid(SnapValid), .SnapPos(SnapPos),
    .SnapZ(SnapZ), .SnapErr(SnapErr)
  );

  quad_decoder #(.POS_W(32), .PPR_W(16), .ERR_W(16), .ZHOME(1'b1)) u_dut_h (
    .Clk(Clk), .rsetN(rsetN), .Ai(Ai), .Bi(Bi), .Zi(Zi), .Clr(Clr), .SnapReq(SnapReq),
    .Position(Position_h), .ZCount(ZCount_h), .PPR(PPR_h), .CycleDone(CycleDone_h), .Dir(Dir_h),
    .ErrCount(ErrCount_h), .ErrFlag(ErrFlag_h), .SnapValid(SnapValid_h), .SnapPos(SnapPos_h),
    .SnapZ(SnapZ_h), .SnapErr(SnapErr_h)
  );

  typedef struct {
    logic [31:0] pos;
    logic [31:0] posh;
    logic [31:0] zc;
    logic [15:0] ppr;
    logic        cd;
    logic        dir;
    logic [15:0] err;
    logic        ef;
    logic        sv;
    logic [31:0] sp;
    logic [31:0] sz;
    logic [15:0] se;
  } exp_t;

  exp_t q[$];
  exp_t m;
  logic        m_armed, m_prevz, m_zseen;
  logic [1:0]  m_prev;
  logic [15:0] m_edge;

  int n_checks = 0;
  int n_errors = 0;
  int cd_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_armed = 1'b0; m_prevz = 1'b0; m_zseen = 1'b0; m_prev = 2'b00; m_edge = '0;
    q.delete();
  endtask

  task automatic model_update(input logic [1:0] ab, input logic z, input logic clr, input logic snap);
    exp_t n;
    int   d;
    logic zr, valid;
    n = m;
    n.cd = 1'b0;
    n.sv = snap;
    if (snap) begin
      n.sp = m.pos; n.sz = m.zc; n.se = m.err;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (clr) begin
      n.pos = '0; n.posh = '0; n.zc = '0; n.ppr = '0; n.err = '0; n.ef = 1'b0;
      m_edge = '0; m_zseen = 1'b0;
    end else begin
      d     = (gidx(ab) - gidx(m_prev)) & 3;
      zr    = z & ~m_prevz;
      valid = (d == 1) || (d == 3);
      if (d == 1) begin n.pos = m.pos + 1; n.posh = m.posh + 1; n.dir = 1'b1; end
      if (d == 3) begin n.pos = m.pos - 1; n.posh = m.posh - 1; n.dir = 1'b0; end
      if (d == 2) begin
        if (m.err != 16'hFFFF) n.err = m.err + 1;
        n.ef = 1'b1;
      end
      if (zr) begin
        n.zc = m.zc + 1;
        if (m_zseen) begin n.ppr = m_edge; n.cd = 1'b1; end
        m_zseen = 1'b1;
        m_edge  = valid ? 16'd1 : 16'd0;
        n.posh  = '0;
      end else if (valid && m_edge != 16'hFFFF) begin
        m_edge = m_edge + 1;
      end
    end
    m_prev  = ab;
    m_prevz = z;
    m = n;
    q.push_back(n);
  endtask

  task automatic cyc(input logic [1:0] ab, input logic z = 1'b0, input logic clr = 1'b0,
                     input logic snap = 1'b0);
    exp_t e;
    @(negedge Clk);
    {Ai, Bi} = ab; Zi = z; Clr = clr; SnapReq = snap;
    model_update(ab, z, clr, snap);
    @(posedge Clk);
    #1;
    e = q.pop_front();
    chk("pos", Position, e.pos);
    chk("pos_zhome", Position_h, e.posh);
    chk("zcount", ZCount, e.zc);
    chk("ppr", PPR, e.ppr);
    chk("cycle_done", CycleDone, e.cd);
    chk("dir", Dir, e.dir);
    chk("err", ErrCount, e.err);
    chk("err_flag", ErrFlag, e.ef);
    chk("snap_valid", SnapValid, e.sv);
    if (e.sv) begin
      chk("snap_pos", SnapPos, e.sp);
      chk("snap_z", SnapZ, e.sz);
      chk("snap_err", SnapErr, e.se);
    end
    if (CycleDone) cd_seen++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pos"}, Position, 32'd0);
    chk({tag, "_zcount"}, ZCount, 32'd0);
    chk({tag, "_ppr"}, PPR, 32'd0);
    chk({tag, "_cd"}, CycleDone, 32'd0);
    chk({tag, "_dir"}, Dir, 32'd0);
    chk({tag, "_err"}, ErrCount, 32'd0);
    chk({tag, "_flag"}, ErrFlag, 32'd0);
    chk({tag, "_sv"}, SnapValid, 32'd0);
    chk({tag, "_spos"}, SnapPos, 32'd0);
  endtask

  logic [1:0] gseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] rseq [6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [1:0] ab_now;

  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    @(negedge Clk);
    rsetN = 1'b1;
    repeat (5) cyc(2'b00);

    for (int r = 0; r < 4; r++)
      for (int k = 1; k <= 4; k++)
        repeat (3) cyc(gseq[k % 4]);
    chk("fwd16_pos", Position, 32'd16);
    chk("fwd16_dir", Dir, 32'd1);
    for (int k = 0; k < 6; k++) repeat (3) cyc(rseq[k]);
    chk("rev6_pos", Position, 32'd10);
    chk("rev6_dir", Dir, 32'd0);

    cyc(2'b11, 1'b1); cyc(2'b11, 1'b1); cyc(2'b11, 1'b0);
    chk("z1_zcount", ZCount, 32'd1);
    chk("z1_zhome_pos", Position_h, 32'd0);
    cd_seen = 0;
    ab_now = 2'b11;
    for (int i = 1; i <= 2000; i++) begin
      ab_now = gseq[(2 + i) % 4];
      cyc(ab_now);
    end
    cyc(ab_now, 1'b1); cyc(ab_now, 1'b1); cyc(ab_now, 1'b0);
    chk("z2_zcount", ZCount, 32'd2);
    chk("z2_ppr", PPR, 32'd2000);
    chk("z2_cd_pulses", cd_seen, 32'd1);
    chk("z2_zhome_pos", Position_h, 32'd0);

    cyc(2'b00);
    chk("ill_err", ErrCount, 32'd1);
    chk("ill_flag", ErrFlag, 32'd1);
    chk("ill_pos", Position, 32'd2010);
    for (int i = 0; i < 70000; i++) cyc((i % 2 == 0) ? 2'b11 : 2'b00);
    chk("err_sat", ErrCount, 32'h0000_FFFF);

    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b01); cyc(2'b11); cyc(2'b10);
    chk("neg3_pos", Position, 32'hFFFF_FFFD);
    cyc(2'b11, 1'b0, 1'b0, 1'b1);
    chk("snap_valid_step", SnapValid, 32'd1);
    chk("snap_pos_m3", SnapPos, 32'hFFFF_FFFD);
    chk("pos_m2", Position, 32'hFFFF_FFFE);
    cyc(2'b11, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 1'b0, 1'b0, 1'b1);
    chk("b2b_snap_valid", SnapValid, 32'd1);

    cyc(2'b01, 1'b1, 1'b1);
    chk("clr_pos", Position, 32'd0);
    chk("clr_zcount", ZCount, 32'd0);
    chk("clr_cd", CycleDone, 32'd0);
    cyc(2'b00, 1'b1);
    chk("post_clr_pos", Position, 32'd1);
    cyc(2'b00, 1'b0, 1'b1, 1'b1);
    chk("clr_snap_pos", SnapPos, 32'd1);

    cyc(2'b10); cyc(2'b11);
    #2;
    rsetN = 1'b0;
    #1;
    chk_all_zero("async");
    model_reset();
    @(negedge Clk);
    rsetN = 1'b1;
    cyc(2'b11, 1'b0, 1'b0, 1'b1);
    cyc(2'b01);
    chk("rearm_snap_pos", SnapPos, 32'd0);
    cyc(2'b00);
    chk("rearm_pos", Position, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Converts the conditioned encoder lines (A, B, Z, output of the input sieve stage) into a signed x4 position count, a Z-index count, a measured edges-per-revolution (PPR) value and an illegal-transition error count.
- Sits between the input sieve stage and the signal router / UART report path.
- Provides a one-cycle snapshot handshake so the UART side reads a coherent set of counters.

Parameters:
POS_W, 32, width of signed position and snapshot position
PPR_W, 16, width of edge-per-revolution counter and PPR output
ERR_W, 16, width of illegal-transition error counter
ZHOME, 0, 1 = clear Position on every Z rising edge

Ports:
Clk  in  1  system clock; all logic on rising edge
rsetN  in  1  asynchronous active-low reset
Ai  in  1  conditioned A channel, already synchronous to Clk
Bi  in  1  conditioned B channel, already synchronous to Clk
Zi  in  1  conditioned Z channel, already synchronous to Clk
Clr  in  1  synchronous clear, active high
SnapReq  in  1  snapshot request pulse
Position  out  POS_W  signed x4 position
ZCount  out  32  number of Z rising edges, wraps
PPR  out  PPR_W  quadrature edges counted between the last two Z rising edges
CycleDone  out  1  one-cycle pulse when PPR updates
Dir  out  1  1 = last valid step forward
ErrCount  out  ERR_W  illegal transitions, saturating
ErrFlag  out  1  sticky, set on any illegal transition
SnapValid  out  1  one-cycle pulse, snapshot outputs valid
SnapPos  out  POS_W  captured Position
SnapZ  out  32  captured ZCount
SnapErr  out  ERR_W  captured ErrCount

Behaviour:
- Reset (rsetN=0, async):
  - All outputs 0; internal PrevAB=00, PrevZ=0, Armed=0, ZSeen=0, EdgeCnt=0.
- Arming:
  - First cycle with Armed=0: load PrevAB={Ai,Bi}, PrevZ=Zi, set Armed=1.
  - No counting and no Z detection in that cycle.
- Step decode when Armed=1, comparing {Ai,Bi} to PrevAB each cycle; PrevAB <= {Ai,Bi} every cycle.
  - Forward (+1), A leads: 00->10, 10->11, 11->01, 01->00. Position +1, Dir <= 1.
  - Reverse (-1): the inverse transitions. Position -1, Dir <= 0.
  - Unchanged: no action.
  - Both bits changed (illegal): Position and Dir unchanged; ErrCount +1, saturating at all-ones; ErrFlag <= 1.
  - Position is two's complement and wraps at POS_W.
- Edge counter:
  - EdgeCnt +1 on every valid step, either direction; saturates at all-ones.
- Z handling, rising edge = Zi=1 and PrevZ=0; PrevZ <= Zi every armed cycle:
  - ZCount +1, wraps at 32 bits.
  - If ZSeen=1: PPR <= EdgeCnt (excluding the same-cycle step) and CycleDone=1 for exactly that cycle.
  - If ZSeen=0: PPR unchanged, no CycleDone; set ZSeen=1.
  - EdgeCnt <= 1 if a valid step occurs in the same cycle, else 0.
  - If ZHOME=1, Position <= 0. Z wins over a same-cycle step.
- Clr=1:
  - Position, ZCount, PPR, EdgeCnt, ErrCount, ErrFlag, ZSeen <= 0; CycleDone=0.
  - PrevAB/PrevZ reloaded from the inputs; Armed stays 1.
  - Clr overrides any step or Z event in the same cycle.
  - A pending snapshot still completes, using the pre-clear values.
- Snapshot:
  - On the cycle SnapReq=1 is sampled, capture Position, ZCount and ErrCount as registered before that cycle's update.
  - Next cycle: SnapValid=1 for one cycle; Snap* hold until the next capture.
  - Back-to-back requests give back-to-back SnapValid pulses.
  - A request while Armed=0 still captures (values are 0).
- Latency:
  - Counters reflect an input change 1 cycle after it is sampled.
  - CycleDone is asserted in that same update cycle.

Test Plan:
- Reset then hold AB=00, 5 cycles -> all outputs 0, SnapValid 0; first cycle after release makes no count.
- Forward sequence 00,10,11,01,00 repeated 4 times, one state per 3 cycles -> Position=16, Dir=1, ErrCount=0; then reverse 6 steps -> Position=10, Dir=0.
- Z pulse, then 2000 forward steps, then Z pulse -> first Z: ZCount=1, no CycleDone; second Z: ZCount=2, PPR=2000, CycleDone exactly one cycle; with ZHOME=1, Position=0 after each Z.
- Step 00->11 directly -> ErrCount=1, ErrFlag=1, Position unchanged; force 70000 illegal toggles with ERR_W=16 -> ErrCount=0xFFFF.
- Position=-3 (three reverse steps), SnapReq pulse coinciding with a forward step -> next cycle SnapValid=1, SnapPos=-3, Position=-2.
- Clr asserted in the same cycle as a Z rising edge and a step -> all counters 0, no CycleDone; a following step gives Position=±1. Assert rsetN=0 mid-sequence -> outputs 0 immediately, without waiting for a Clk edge.
